snn_network_seq: RTL and testbench

Time-multiplexed successor to the fully-parallel SNN network. It runs a layered LIF network: input spikes feed a hidden layer, and the hidden layer feeds an output layer. One shared LIF datapath is sequenced over all neurons, so neuron state lives in register arrays. Weights are run-time writable, each timestep is started by a valid/ready handshake, and per-output spike counters support rate-coded readout.

---
 rtl/snn_network_seq.sv | 167 ++++++++++++++++
 tb/tb_snn_network_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_network_seq.sv
// Time-multiplexed two-layer LIF spiking network: one shared neuron datapath walks
// the hidden layer, then the output layer, for each accepted input timestep.
module snn_network_seq #(
  parameter int NUM_IN      = 16,
  parameter int NUM_HIDDEN  = 16,
  parameter int NUM_OUT     = 8,
  parameter int W_WIDTH     = 8,
  parameter int V_WIDTH     = 12,
  parameter int THR         = 64,
  parameter int DECAY_SHIFT = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int ADDR_W      = $clog2(NUM_HIDDEN*NUM_IN + NUM_OUT*NUM_HIDDEN)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_spk,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic signed [W_WIDTH-1:0]    wr_data,
  input  logic                         state_clear,
  input  logic                         clear_cnt,
  output logic [NUM_OUT-1:0]           out_spk,
  output logic                         out_valid,
  output logic                         busy,
  output logic [NUM_OUT*CNT_WIDTH-1:0] spk_cnt,
  output logic [NUM_OUT-1:0]           io_oeb
);

  localparam int NUM_W    = NUM_HIDDEN*NUM_IN + NUM_OUT*NUM_HIDDEN;
  localparam int OUT_BASE = NUM_HIDDEN*NUM_IN;
  localparam int NUM_V    = NUM_HIDDEN + NUM_OUT;
  localparam int MAX_N    = (NUM_HIDDEN > NUM_OUT) ? NUM_HIDDEN : NUM_OUT;
  localparam int IDX_W    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int HID_AW   = (NUM_HIDDEN > 1) ? $clog2(NUM_HIDDEN) : 1;
  localparam int OUT_AW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int V_AW     = (NUM_V > 1) ? $clog2(NUM_V) : 1;
  localparam int FAN      = (NUM_IN > NUM_HIDDEN) ? NUM_IN : NUM_HIDDEN;
  localparam int ACC_W    = V_WIDTH + W_WIDTH + $clog2(FAN) + 2;

  localparam logic signed [ACC_W-1:0]   VMAX  = ACC_W'((1 << (V_WIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0]   VMIN  = ACC_W'(-(1 << (V_WIDTH-1)));
  localparam logic signed [V_WIDTH-1:0] THR_V = V_WIDTH'(THR);

  typedef enum logic [1:0] {S_IDLE, S_HID, S_OUT, S_DONE} state_t;

  state_t                      state_q;
  logic [IDX_W-1:0]            idx_q;
  logic [NUM_IN-1:0]           in_spk_q;
  logic [NUM_HIDDEN-1:0]       hid_spk_q;
  logic [NUM_OUT-1:0]          stage_q;
  logic [NUM_OUT-1:0]          out_spk_q;
  logic                        out_valid_q;
  logic signed [W_WIDTH-1:0]   w_q   [NUM_W];
  logic signed [V_WIDTH-1:0]   v_q   [NUM_V];
  logic [CNT_WIDTH-1:0]        cnt_q [NUM_OUT];

  logic [V_AW-1:0]             v_addr;
  logic signed [ACC_W-1:0]     syn_i;
  logic signed [ACC_W-1:0]     v_ext;
  logic signed [ACC_W-1:0]     v_sum;
  logic signed [V_WIDTH-1:0]   v_d;
  logic                        fire_d;

  function automatic logic signed [V_WIDTH-1:0] sat_v(input logic signed [ACC_W-1:0] x);
    if (x > VMAX)      return {1'b0, {(V_WIDTH-1){1'b1}}};
    else if (x < VMIN) return {1'b1, {(V_WIDTH-1){1'b0}}};
    else               return x[V_WIDTH-1:0];
  endfunction

  // Synaptic current of the neuron under idx_q: the hidden layer reads the latched
  // input spikes, the output layer reads this timestep's hidden spikes.
  always_comb begin
    syn_i = '0;
    if (state_q == S_OUT) begin
      for (int n = 0; n < NUM_HIDDEN; n++)
        if (hid_spk_q[n])
          syn_i = syn_i + ACC_W'(w_q[ADDR_W'(OUT_BASE + int'(idx_q)*NUM_HIDDEN + n)]);
    end else begin
      for (int j = 0; j < NUM_IN; j++)
        if (in_spk_q[j])
          syn_i = syn_i + ACC_W'(w_q[ADDR_W'(int'(idx_q)*NUM_IN + j)]);
    end
  end

  // Output membranes sit after the hidden ones in the shared array.
  always_comb begin
    v_addr = (state_q == S_OUT) ? V_AW'(NUM_HIDDEN + int'(idx_q)) : V_AW'(int'(idx_q));
    v_ext  = ACC_W'(v_q[v_addr]);
    v_sum  = v_ext - (v_ext >>> DECAY_SHIFT) + syn_i;
    v_d    = sat_v(v_sum);
    fire_d = (v_d >= THR_V);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      in_spk_q    <= '0;
      hid_spk_q   <= '0;
      stage_q     <= '0;
      out_spk_q   <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_W; i++)   w_q[i]   <= '0;
      for (int i = 0; i < NUM_V; i++)   v_q[i]   <= '0;
      for (int k = 0; k < NUM_OUT; k++) cnt_q[k] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_en && (int'(wr_addr) < NUM_W)) w_q[wr_addr] <= wr_data;
          if (state_clear)
            for (int i = 0; i < NUM_V; i++) v_q[i] <= '0;
          if (in_valid) begin
            in_spk_q <= in_spk;
            idx_q    <= '0;
            state_q  <= S_HID;
          end
        end
        S_HID: begin
          v_q[v_addr]                  <= fire_d ? '0 : v_d;
          hid_spk_q[idx_q[HID_AW-1:0]] <= fire_d;
          if (idx_q == IDX_W'(NUM_HIDDEN - 1)) begin
            idx_q   <= '0;
            state_q <= S_OUT;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_OUT: begin
          v_q[v_addr]                <= fire_d ? '0 : v_d;
          stage_q[idx_q[OUT_AW-1:0]] <= fire_d;
          if (idx_q == IDX_W'(NUM_OUT - 1)) begin
            idx_q   <= '0;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          out_spk_q   <= stage_q;
          out_valid_q <= 1'b1;
          for (int k = 0; k < NUM_OUT; k++)
            if (stage_q[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // Placed after the DONE increment so a simultaneous clear wins.
      if (clear_cnt)
        for (int k = 0; k < NUM_OUT; k++) cnt_q[k] <= '0;
    end
  end

  always_comb begin
    spk_cnt = '0;
    for (int k = 0; k < NUM_OUT; k++) spk_cnt[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_spk   = out_spk_q;
  assign out_valid = out_valid_q;
  assign io_oeb    = '0;

endmodule

// File: tb/tb_snn_network_seq.sv
// Bench for snn_network_seq: directed scenarios plus random timesteps, all checked
// against a layer-by-layer integer model of the network kept in this file.
module tb_snn_network_seq;

  localparam int NUM_IN      = 16;
  localparam int NUM_HIDDEN  = 16;
  localparam int NUM_OUT     = 8;
  localparam int W_WIDTH     = 8;
  localparam int V_WIDTH     = 12;
  localparam int THR         = 64;
  localparam int DECAY_SHIFT = 2;
  localparam int CNT_WIDTH   = 8;
  localparam int NUM_W       = NUM_HIDDEN*NUM_IN + NUM_OUT*NUM_HIDDEN;
  localparam int ADDR_W      = $clog2(NUM_W);
  localparam int OUT_BASE    = NUM_HIDDEN*NUM_IN;
  localparam int LAT         = NUM_HIDDEN + NUM_OUT + 1;
  localparam int VMAX        = (1 << (V_WIDTH-1)) - 1;
  localparam int VMIN        = -(1 << (V_WIDTH-1));
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  logic                         clk = 1'b0;
  logic                         reset = 1'b0;
  logic [NUM_IN-1:0]            in_spk = '0;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  logic                         wr_en = 1'b0;
  logic [ADDR_W-1:0]            wr_addr = '0;
  logic signed [W_WIDTH-1:0]    wr_data = '0;
  logic                         state_clear = 1'b0;
  logic                         clear_cnt = 1'b0;
  logic [NUM_OUT-1:0]           out_spk;
  logic                         out_valid;
  logic                         busy;
  logic [NUM_OUT*CNT_WIDTH-1:0] spk_cnt;
  logic [NUM_OUT-1:0]           io_oeb;

  int n_checks = 0;
  int n_fail   = 0;

  int mw   [NUM_W];
  int mvh  [NUM_HIDDEN];
  int mvo  [NUM_OUT];
  int mcnt [NUM_OUT];
  logic [NUM_OUT-1:0] mout;

  snn_network_seq #(
    .NUM_IN(NUM_IN), .NUM_HIDDEN(NUM_HIDDEN), .NUM_OUT(NUM_OUT), .W_WIDTH(W_WIDTH),
    .V_WIDTH(V_WIDTH), .THR(THR), .DECAY_SHIFT(DECAY_SHIFT), .CNT_WIDTH(CNT_WIDTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .in_spk(in_spk), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .state_clear(state_clear),
    .clear_cnt(clear_cnt), .out_spk(out_spk), .out_valid(out_valid), .busy(busy),
    .spk_cnt(spk_cnt), .io_oeb(io_oeb)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int msat(input int x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_W; i++) mw[i] = 0;
    for (int n = 0; n < NUM_HIDDEN; n++) mvh[n] = 0;
    for (int k = 0; k < NUM_OUT; k++) begin mvo[k] = 0; mcnt[k] = 0; end
    mout = '0;
  endfunction

  function automatic void model_clear_v();
    for (int n = 0; n < NUM_HIDDEN; n++) mvh[n] = 0;
    for (int k = 0; k < NUM_OUT; k++) mvo[k] = 0;
  endfunction

  function automatic void model_step(input logic [NUM_IN-1:0] spk);
    logic [NUM_HIDDEN-1:0] hs;
    int isum, nv;
    hs = '0;
    for (int n = 0; n < NUM_HIDDEN; n++) begin
      isum = 0;
      for (int j = 0; j < NUM_IN; j++) if (spk[j]) isum += mw[n*NUM_IN + j];
      nv = msat(mvh[n] - (mvh[n] >>> DECAY_SHIFT) + isum);
      if (nv >= THR) begin hs[n] = 1'b1; mvh[n] = 0; end else mvh[n] = nv;
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      isum = 0;
      for (int n = 0; n < NUM_HIDDEN; n++) if (hs[n]) isum += mw[OUT_BASE + k*NUM_HIDDEN + n];
      nv = msat(mvo[k] - (mvo[k] >>> DECAY_SHIFT) + isum);
      if (nv >= THR) begin mout[k] = 1'b1; mvo[k] = 0; end else begin mout[k] = 1'b0; mvo[k] = nv; end
    end
    for (int k = 0; k < NUM_OUT; k++) if (mout[k] && mcnt[k] < CNT_MAX) mcnt[k]++;
  endfunction

  function automatic logic [NUM_OUT*CNT_WIDTH-1:0] exp_cnt();
    logic [NUM_OUT*CNT_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_OUT; k++) r[k*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(mcnt[k]);
    return r;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; wr_en = 1'b0; state_clear = 1'b0; clear_cnt = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic wr_weight(input int addr, input int data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_data = W_WIDTH'(data);
    @(negedge clk);
    wr_en = 1'b0;
    if (addr < NUM_W) mw[addr] = data;
  endtask

  // Drives one accepted timestep (optionally with clear/write in the accept cycle)
  // and returns the number of clock edges from accept to the out_valid pulse.
  task automatic run_step(input logic [NUM_IN-1:0] spk, input bit clr, input bit wr,
                          input int wa, input int wd, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    in_spk = spk; in_valid = 1'b1; state_clear = clr;
    wr_en = wr; wr_addr = ADDR_W'(wa); wr_data = W_WIDTH'(wd);
    @(posedge clk); #1;
    in_valid = 1'b0; state_clear = 1'b0; wr_en = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin lat = c; break; end
    end
    if (clr) model_clear_v();
    if (wr && wa < NUM_W) mw[wa] = wd;
    model_step(spk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_in_reset: got %b want 0", busy); end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (out_spk !== '0) begin n_fail++; $display("FAIL reset_out_spk: got %h want 0", out_spk); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (spk_cnt !== '0) begin n_fail++; $display("FAIL reset_spk_cnt: got %h want 0", spk_cnt); end
    n_checks++; if (io_oeb !== '0) begin n_fail++; $display("FAIL reset_io_oeb: got %h want 0", io_oeb); end
  endtask

  task automatic test_basic();
    int lat;
    do_reset();
    wr_weight(0, 40);
    wr_weight(OUT_BASE, 64);
    for (int s = 0; s < 2; s++) begin
      run_step(16'h0001, 1'b0, 1'b0, 0, 0, lat);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_lat step%0d: got %0d want %0d", s, lat, LAT); end
      n_checks++; if (out_spk !== mout) begin n_fail++; $display("FAIL basic_out step%0d: got %h want %h", s, out_spk, mout); end
    end
    n_checks++; if (out_spk !== 8'h01) begin n_fail++; $display("FAIL basic_o0_spike: got %h want 01", out_spk); end
    n_checks++; if (spk_cnt !== exp_cnt()) begin n_fail++; $display("FAIL basic_cnt: got %h want %h", spk_cnt, exp_cnt()); end
    repeat (5) @(negedge clk);
    n_checks++; if (out_spk !== mout) begin n_fail++; $display("FAIL basic_hold: got %h want %h", out_spk, mout); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pulse: got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    int lat;
    logic [NUM_IN-1:0] pat [5];
    do_reset();
    for (int j = 0; j < NUM_IN; j++) wr_weight(j, 127);
    wr_weight(OUT_BASE, 64);
    run_step(16'hFFFF, 1'b0, 1'b0, 0, 0, lat);
    n_checks++; if (out_spk !== mout) begin n_fail++; $display("FAIL sat_pos_out: got %h want %h", out_spk, mout); end
    for (int j = 0; j < NUM_IN; j++) wr_weight(j, -128);
    for (int s = 0; s < 2; s++) begin
      run_step(16'hFFFF, 1'b0, 1'b0, 0, 0, lat);
      n_checks++; if (out_spk !== mout) begin n_fail++; $display("FAIL sat_neg_out step%0d: got %h want %h", s, out_spk, mout); end
    end
    // From -2048 a drive of 1599 lands one below threshold; a wrapped membrane would fire.
    for (int j = 0; j < NUM_IN; j++) wr_weight(j, (j == NUM_IN-1) ? 99 : 100);
    for (int s = 0; s < 2; s++) begin
      run_step(16'hFFFF, 1'b0, 1'b0, 0, 0, lat);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL sat_lat step%0d: got %0d want %0d", s, lat, LAT); end
      n_checks++; if (out_spk !== mout) begin n_fail++; $display("FAIL sat_recover_out step%0d: got %h want %h", s, out_spk, mout); end
    end
  endtask

  task automatic test_busy_block();
    int lat;
    do_reset();
    wr_weight(0, 40);
    wr_weight(OUT_BASE, 64);
    @(negedge clk);
    in_spk = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    model_step('0);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      in_valid = (c < 20) ? c[0] : 1'b0;
      in_spk   = 16'h0001;
      wr_en    = (c < 20) && (c % 3 == 0);
      wr_addr  = '0;
      wr_data  = 8'sd99;
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin lat = c; break; end
      n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_flags c%0d: got busy=%b ready=%b want 1/0", c, busy, in_ready); end
    end
    wr_en = 1'b0; in_valid = 1'b0;
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL busy_lat: got %0d want %0d", lat, LAT); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL busy_ready_after: got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_not_accepted: got %b want 0", busy); end
    for (int s = 0; s < 2; s++) begin
      run_step(16'h0001, (s == 0), 1'b0, 0, 0, lat);
      n_checks++; if (out_spk !== mout) begin n_fail++; $display("FAIL busy_readback step%0d: got %h want %h", s, out_spk, mout); end
    end
  endtask

  task automatic test_counter_sat();
    int lat;
    int bad_lat;
    do_reset();
    wr_weight(0, 127);
    wr_weight(OUT_BASE, 64);
    bad_lat = 0;
    for (int s = 0; s < 300; s++) begin
      run_step(16'h0001, 1'b0, 1'b0, 0, 0, lat);
      if (lat != LAT) bad_lat++;
    end
    n_checks++; if (bad_lat !== 0) begin n_fail++; $display("FAIL cnt_step_latency: got %0d late steps want 0", bad_lat); end
    n_checks++; if (spk_cnt[CNT_WIDTH-1:0] !== 8'd255) begin n_fail++; $display("FAIL cnt_sat: got %0d want 255", spk_cnt[CNT_WIDTH-1:0]); end
    n_checks++; if (spk_cnt !== exp_cnt()) begin n_fail++; $display("FAIL cnt_vector: got %h want %h", spk_cnt, exp_cnt()); end
    @(negedge clk);
    in_spk = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      clear_cnt = (c == LAT);
      @(posedge clk); #1;
      clear_cnt = 1'b0;
      if (out_valid === 1'b1) begin lat = c; break; end
    end
    model_step(16'h0001);
    for (int k = 0; k < NUM_OUT; k++) mcnt[k] = 0;
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL cnt_clear_lat: got %0d want %0d", lat, LAT); end
    n_checks++; if (spk_cnt !== exp_cnt()) begin n_fail++; $display("FAIL cnt_clear_in_done: got %h want %h", spk_cnt, exp_cnt()); end
    run_step(16'h0001, 1'b0, 1'b0, 0, 0, lat);
    n_checks++; if (spk_cnt !== exp_cnt()) begin n_fail++; $display("FAIL cnt_after_clear: got %h want %h", spk_cnt, exp_cnt()); end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    wr_weight(0, 127);
    wr_weight(1*NUM_IN + 1, 60);
    wr_weight(OUT_BASE, 64);
    run_step(16'h0003, 1'b0, 1'b0, 0, 0, lat);
    n_checks++; if (out_spk !== mout) begin n_fail++; $display("FAIL rmid_pre_out: got %h want %h", out_spk, mout); end
    @(negedge clk);
    in_spk = 16'h0003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_fsm: got busy=%b ready=%b want 0/1", busy, in_ready); end
    n_checks++; if (out_spk !== '0) begin n_fail++; $display("FAIL rmid_out_spk: got %h want 0", out_spk); end
    n_checks++; if (spk_cnt !== '0) begin n_fail++; $display("FAIL rmid_cnt: got %h want 0", spk_cnt); end
    @(negedge clk);
    reset = 1'b1;
    wr_weight(1*NUM_IN + 1, 30);
    wr_weight(OUT_BASE + 1, 64);
    run_step(16'h0003, 1'b0, 1'b0, 0, 0, lat);
    n_checks++; if (out_spk !== mout) begin n_fail++; $display("FAIL rmid_post_out: got %h want %h", out_spk, mout); end
  endtask

  task automatic test_state_clear();
    int lat;
    do_reset();
    wr_weight(0, 40);
    wr_weight(OUT_BASE, 64);
    for (int s = 0; s < 3; s++) run_step(16'h0001, 1'b0, 1'b0, 0, 0, lat);
    n_checks++; if (out_spk !== mout) begin n_fail++; $display("FAIL clr_pre_out: got %h want %h", out_spk, mout); end
    run_step(16'h0001, 1'b1, 1'b0, 0, 0, lat);
    n_checks++; if (out_spk !== 8'h00) begin n_fail++; $display("FAIL clr_step1_repeat: got %h want 00", out_spk); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL clr_lat: got %0d want %0d", lat, LAT); end
    run_step(16'h0001, 1'b1, 1'b1, 0, 70, lat);
    n_checks++; if (out_spk !== mout) begin n_fail++; $display("FAIL same_cycle_write: got %h want %h", out_spk, mout); end
  endtask

  task automatic test_random();
    int lat;
    bit clr, wr;
    int wa, wd;
    logic [NUM_IN-1:0] spk;
    do_reset();
    for (int i = 0; i < NUM_W; i++) wr_weight(i, int'($urandom_range(0, 100)) - 40);
    for (int s = 0; s < 40; s++) begin
      spk = NUM_IN'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      wr  = ($urandom_range(0, 3) == 0);
      wa  = int'($urandom_range(0, (1 << ADDR_W) - 1));
      wd  = int'($urandom_range(0, 255)) - 128;
      run_step(spk, clr, wr, wa, wd, lat);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rand_lat s%0d: got %0d want %0d", s, lat, LAT); end
      n_checks++; if (out_spk !== mout) begin n_fail++; $display("FAIL rand_out s%0d: got %h want %h", s, out_spk, mout); end
      n_checks++; if (spk_cnt !== exp_cnt()) begin n_fail++; $display("FAIL rand_cnt s%0d: got %h want %h", s, spk_cnt, exp_cnt()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_busy_block();
    test_counter_sat();
    test_reset_mid();
    test_state_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
